array_port_arbiter: RTL

//  Shares one single-port synchronous array (the controlArr*_a port set of a synthesized kernel) among
//  N_REQ requesters: kernel instances and the host loader/dumper. Round-robin per access, optional

---
 rtl/arb_pkg.sv | 26 ++
 rtl/rr_picker.sv | 35 +++
 rtl/array_port_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types, defaults and helpers for the array port arbiter.
package arb_pkg;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } arb_state_e;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 1;

  // Index of the set bit in a one-hot vector (0 when the vector is empty).
  function automatic int onehot_to_idx(input logic [7:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) begin
        idx = i;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotate-priority encoder: first active request at or after ptr, wrapping at N.
module rr_picker
  import arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] pos;

  // Scan ptr, ptr+1, ... (mod N) and keep only the first requester found
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(ptr) + k) % N);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  assign idx = IW'(onehot_to_idx(8'(gnt)));

endmodule

// File: rtl/array_port_arbiter.sv
// Shares one single-port read-first array among N_REQ requesters:
// round-robin per access, optional bounded lock, one-cycle issue stage and
// one-cycle read-return tag pipe.
module array_port_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_LOCK = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          lock,
  input  logic [N_REQ-1:0]          we,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      lock_err,
  output logic                      controlArrWEnable_a,
  output logic [ADDR_W-1:0]         controlArrAddr_a,
  output logic [DATA_W-1:0]         controlArrWData_a,
  input  logic [DATA_W-1:0]         controlArrRData_a
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);

  arb_state_e        state;
  logic [IW-1:0]     owner;
  logic [IW-1:0]     ptr;
  logic [CW-1:0]     lock_cnt;
  logic [CW-1:0]     next_cnt;
  logic [N_REQ-1:0]  pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     sel_idx;
  logic              xfer;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              stay_locked;
  logic              forced_rel;
  logic              tag_valid;
  logic [IW-1:0]     tag_idx;

  rr_picker #(.N(N_REQ), .IW(IW)) u_picker (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Grant: round-robin pick when unlocked, only the owner while locked
  always_comb begin
    gnt     = '0;
    sel_idx = pick_idx;
    case (state)
      UNLOCKED: begin
        gnt     = pick_gnt;
        sel_idx = pick_idx;
      end
      LOCKED: begin
        sel_idx = owner;
        if (req[owner]) begin
          gnt[owner] = 1'b1;
        end else begin
          gnt = '0;
        end
      end
      default: begin
        gnt     = '0;
        sel_idx = pick_idx;
      end
    endcase
  end

  assign xfer      = |gnt;
  assign sel_we    = we[sel_idx];
  assign sel_lock  = lock[sel_idx];
  assign sel_addr  = addr[int'(sel_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = wdata[int'(sel_idx)*DATA_W +: DATA_W];

  // Lock bookkeeping: next_cnt is the number of consecutive locked accesses
  // including this one; reaching MAX_LOCK ends the lock after this access.
  always_comb begin
    stay_locked = 1'b0;
    forced_rel  = 1'b0;
    if (state == LOCKED) begin
      next_cnt = lock_cnt + CW'(1);
    end else begin
      next_cnt = CW'(1);
    end
    if (sel_lock) begin
      if (next_cnt < CW'(MAX_LOCK)) begin
        stay_locked = 1'b1;
      end else begin
        forced_rel = 1'b1;
      end
    end else begin
      stay_locked = 1'b0;
    end
  end

  // Arbitration state: pointer, lock state/owner/counter, lock error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNLOCKED;
      owner    <= '0;
      ptr      <= '0;
      lock_cnt <= '0;
      lock_err <= 1'b0;
    end else if (xfer) begin
      ptr      <= (sel_idx == IW'(N_REQ - 1)) ? '0 : sel_idx + IW'(1);
      lock_err <= forced_rel;
      if (stay_locked) begin
        state    <= LOCKED;
        owner    <= sel_idx;
        lock_cnt <= next_cnt;
      end else begin
        state    <= UNLOCKED;
        lock_cnt <= '0;
      end
    end else begin
      lock_err <= 1'b0;
    end
  end

  // Issue stage: drive the RAM port one cycle after acceptance; hold addr/data when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      controlArrWEnable_a <= 1'b0;
      controlArrAddr_a    <= '0;
      controlArrWData_a   <= '0;
    end else if (xfer) begin
      controlArrWEnable_a <= sel_we;
      controlArrAddr_a    <= sel_addr;
      controlArrWData_a   <= sel_wdata;
    end else begin
      controlArrWEnable_a <= 1'b0;
    end
  end

  // Read-return pipe: tag accepted reads, then flag the owner when RAM data arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= 1'b0;
      tag_idx   <= '0;
      rvalid    <= '0;
    end else begin
      tag_valid <= xfer & ~sel_we;
      tag_idx   <= sel_idx;
      rvalid    <= tag_valid ? (N_REQ'(1) << tag_idx) : '0;
    end
  end

  assign rdata = (|rvalid) ? controlArrRData_a : '0;

endmodule
